// File: rtl/life_engine.sv
// life_engine: Game-of-Life generation engine over a WIDTH x HEIGHT register board.
// One generation per step request, swept top to bottom one row per clock and
// written back in place. Rows are loaded through a write port in IDLE and read
// back through a registered display port.
// Optional feature: define LIFE_WRAP_EN to make the board a torus; otherwise
// every off-board cell reads as dead.
module life_engine #(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8,
    parameter int AW     = $clog2(HEIGHT)
) (
    input  logic             ph1,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [AW-1:0]    load_addr,
    input  logic [WIDTH-1:0] load_row,
    input  logic             step,
    output logic             busy,
    output logic             done,
    output logic             extinct,
    output logic [15:0]      gen_count,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_row
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SWEEP = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [AW-1:0] LAST_ROW = AW'(HEIGHT - 1);

    logic [1:0]       state;
    logic [AW-1:0]    r;
    logic [WIDTH-1:0] board [HEIGHT];
    logic [WIDTH-1:0] prev_orig;
    logic             any_live;

    logic [WIDTH-1:0] cur_row;
    logic [WIDTH-1:0] above_row;
    logic [WIDTH-1:0] below_row;
    logic [WIDTH-1:0] top_bnd;
    logic [WIDTH-1:0] bot_bnd;
    logic [WIDTH-1:0] next_row;
    logic [WIDTH+1:0] above_e;
    logic [WIDTH+1:0] cur_e;
    logic [WIDTH+1:0] below_e;
    logic [AW-1:0]    below_idx;
    logic             load_in_range;
    logic             rd_in_range;

`ifdef LIFE_WRAP_EN
    logic [WIDTH-1:0] first_orig;
`endif

    // Address range qualification; trivially true when HEIGHT fills the address space.
    generate
        if ((2 ** AW) == HEIGHT) begin : g_full_range
            assign load_in_range = 1'b1;
            assign rd_in_range   = 1'b1;
        end else begin : g_part_range
            localparam logic [AW:0] HEIGHT_W = (AW + 1)'(HEIGHT);
            assign load_in_range = ({1'b0, load_addr} < HEIGHT_W);
            assign rd_in_range   = ({1'b0, rd_addr} < HEIGHT_W);
        end
    endgenerate

    assign busy = (state == SWEEP);
    assign done = (state == DONE);

    // Assemble the three-row neighbourhood of the row being swept, with edge padding.
    always_comb begin
        below_idx = (r == LAST_ROW) ? '0 : r + 1'b1;
        cur_row   = board[r];
`ifdef LIFE_WRAP_EN
        // Sweep runs top-down, so the last row is still the original generation at r==0.
        top_bnd = board[HEIGHT-1];
        bot_bnd = first_orig;
`else
        top_bnd = '0;
        bot_bnd = '0;
`endif
        above_row = (r == '0) ? top_bnd : prev_orig;
        below_row = (r == LAST_ROW) ? bot_bnd : board[below_idx];
`ifdef LIFE_WRAP_EN
        above_e = {above_row[0], above_row, above_row[WIDTH-1]};
        cur_e   = {cur_row[0], cur_row, cur_row[WIDTH-1]};
        below_e = {below_row[0], below_row, below_row[WIDTH-1]};
`else
        above_e = {1'b0, above_row, 1'b0};
        cur_e   = {1'b0, cur_row, 1'b0};
        below_e = {1'b0, below_row, 1'b0};
`endif
    end

    // Neighbour count and survival/birth rule for every column of the swept row.
    always_comb begin
        logic [3:0] sum;
        next_row = '0;
        sum      = '0;
        for (int unsigned c = 0; c < WIDTH; c++) begin
            // Extended vectors are offset by one: column c sits at bit c+1.
            sum = 4'(above_e[c]) + 4'(above_e[c+1]) + 4'(above_e[c+2])
                + 4'(cur_e[c])                      + 4'(cur_e[c+2])
                + 4'(below_e[c]) + 4'(below_e[c+1]) + 4'(below_e[c+2]);
            next_row[c] = (sum == 4'd3) || (cur_row[c] && (sum == 4'd2));
        end
    end

    // Control FSM, sweep bookkeeping and generation statistics.
    always_ff @(posedge ph1) begin
        if (reset) begin
            state     <= IDLE;
            r         <= '0;
            prev_orig <= '0;
            any_live  <= 1'b0;
            extinct   <= 1'b0;
            gen_count <= '0;
`ifdef LIFE_WRAP_EN
            first_orig <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (step) begin
                        state    <= SWEEP;
                        r        <= '0;
                        any_live <= 1'b0;
                    end
                end
                SWEEP: begin
                    prev_orig <= cur_row;
`ifdef LIFE_WRAP_EN
                    if (r == '0) begin
                        first_orig <= cur_row;
                    end
`endif
                    any_live <= any_live | (|next_row);
                    if (r == LAST_ROW) begin
                        // Statistics land on the edge that enters DONE, so the final row is folded in here.
                        state     <= DONE;
                        extinct   <= ~(any_live | (|next_row));
                        gen_count <= gen_count + 16'd1;
                    end else begin
                        r <= r + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Board storage: cleared on reset, loaded in IDLE, rewritten row by row in SWEEP.
    always_ff @(posedge ph1) begin
        if (reset) begin
            for (int unsigned i = 0; i < HEIGHT; i++) begin
                board[i] <= '0;
            end
        end else if (state == IDLE) begin
            if (load_valid && load_in_range) begin
                board[load_addr] <= load_row;
            end
        end else if (state == SWEEP) begin
            board[r] <= next_row;
        end
    end

    // Registered display read port.
    always_ff @(posedge ph1) begin
        if (reset) begin
            rd_row <= '0;
        end else begin
            rd_row <= rd_in_range ? board[rd_addr] : '0;
        end
    end

endmodule
